// File: rtl/vrf_access_seq.sv
// Vector register access sequencer: turns whole-register read/write commands
// into per-bank SRAM request streams and returns read data through a 2-entry
// output FIFO with valid/ready flow control.
module vrf_access_seq #(
    parameter int unsigned NumBanks   = 4,
    parameter int unsigned NumVRs     = 32,
    parameter int unsigned ElemsPerVR = 32,
    parameter int unsigned DataWidth  = 32,
    localparam int unsigned BeatsPerVR = ElemsPerVR / NumBanks,
    localparam int unsigned AddrWidth  = $clog2(NumVRs * BeatsPerVR),
    localparam int unsigned VlWidth    = $clog2(ElemsPerVR) + 1,
    localparam int unsigned VregWidth  = $clog2(NumVRs)
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic                            i_cmd_write,
    input  logic [VregWidth-1:0]            i_cmd_vreg,
    input  logic [VlWidth-1:0]              i_cmd_vl,
    input  logic                            i_wr_valid,
    output logic                            o_wr_ready,
    input  logic [NumBanks*DataWidth-1:0]   i_wr_data,
    output logic                            o_rd_valid,
    input  logic                            i_rd_ready,
    output logic [NumBanks*DataWidth-1:0]   o_rd_data,
    output logic [NumBanks-1:0]             o_rd_mask,
    output logic                            o_rd_last,
    output logic                            o_done,
    output logic [NumBanks-1:0]             o_bank_re,
    output logic [NumBanks-1:0]             o_bank_we,
    output logic [NumBanks*AddrWidth-1:0]   o_bank_r_addr,
    output logic [NumBanks*AddrWidth-1:0]   o_bank_w_addr,
    output logic [NumBanks*DataWidth-1:0]   o_bank_wdata,
    input  logic [NumBanks*DataWidth-1:0]   i_bank_rdata
);

    localparam int unsigned BeatCntW  = $clog2(BeatsPerVR) + 1;
    localparam int unsigned BankShift = $clog2(NumBanks);
    localparam int unsigned ElemW     = VlWidth + 2;
    localparam int unsigned LaneW     = NumBanks * DataWidth;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR       = 2'd1,
        S_RD       = 2'd2,
        S_RD_DRAIN = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [VregWidth-1:0]            r_vreg;
    logic [VlWidth-1:0]              r_vl;
    logic [BeatCntW-1:0]             r_beat;
    logic [BeatCntW-1:0]             r_nbeats;
    logic                            r_done;

    logic                            r_inflight;
    logic [NumBanks-1:0]             r_infl_mask;
    logic                            r_infl_last;

    logic [1:0][LaneW-1:0]           r_fifo_data;
    logic [1:0][NumBanks-1:0]        r_fifo_mask;
    logic [1:0]                      r_fifo_last;
    logic                            r_wr_ptr;
    logic                            r_rd_ptr;
    logic [1:0]                      r_count;

    logic [VlWidth-1:0]              w_vl_clamped;
    logic [VlWidth:0]                w_vl_sum;
    logic [BeatCntW-1:0]             w_nbeats_in;
    logic [ElemW-1:0]                w_elem_base;
    logic [NumBanks-1:0]             w_mask;
    logic [AddrWidth-1:0]            w_addr;
    logic                            w_last_beat;
    logic                            w_accept;
    logic                            w_wr_fire;
    logic                            w_issue;
    logic                            w_rd_finish;
    logic                            w_pop;
    logic                            w_head_last;
    logic [LaneW-1:0]                w_rdata_masked;

    // Command decode: clamp vl and derive the beat count.
    always_comb begin
        w_vl_clamped = (i_cmd_vl > VlWidth'(ElemsPerVR)) ? VlWidth'(ElemsPerVR) : i_cmd_vl;
        w_vl_sum     = (VlWidth+1)'(w_vl_clamped) + (VlWidth+1)'(NumBanks - 1);
        w_nbeats_in  = BeatCntW'(w_vl_sum >> BankShift);
    end

    // Current-beat lane mask, shared bank address and last-beat flag.
    always_comb begin
        w_elem_base = ElemW'(r_beat) * ElemW'(NumBanks);
        for (int i = 0; i < NumBanks; i++) begin
            w_mask[i] = (w_elem_base + ElemW'(i)) < ElemW'(r_vl);
        end
        w_addr      = AddrWidth'(r_vreg) * AddrWidth'(BeatsPerVR) + AddrWidth'(r_beat);
        w_last_beat = (r_beat == (r_nbeats - BeatCntW'(1)));
    end

    // FIFO head view and pop handshake.
    always_comb begin
        o_rd_valid  = (r_count != 2'd0);
        w_head_last = r_fifo_last[r_rd_ptr];
        o_rd_data   = o_rd_valid ? r_fifo_data[r_rd_ptr] : '0;
        o_rd_mask   = o_rd_valid ? r_fifo_mask[r_rd_ptr] : '0;
        o_rd_last   = o_rd_valid && w_head_last;
        w_pop       = o_rd_valid && i_rd_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake strobes; reads issue only while the
    // FIFO plus the in-flight beat leaves room after this cycle's pop.
    always_comb begin
        w_state_nxt = r_state;
        o_cmd_ready = 1'b0;
        o_wr_ready  = 1'b0;
        w_accept    = 1'b0;
        w_wr_fire   = 1'b0;
        w_issue     = 1'b0;
        w_rd_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                w_accept    = i_cmd_valid;
                if (w_accept && (w_vl_clamped != '0)) begin
                    w_state_nxt = i_cmd_write ? S_WR : S_RD;
                end
            end
            S_WR: begin
                o_wr_ready = 1'b1;
                w_wr_fire  = i_wr_valid;
                if (w_wr_fire && w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                w_issue = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
                if (w_issue && w_last_beat) begin
                    w_state_nxt = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: begin
                w_rd_finish = w_pop && w_head_last;
                if (w_rd_finish) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // SRAM request ports; idle lanes hold zero.
    always_comb begin
        o_bank_re     = '0;
        o_bank_we     = '0;
        o_bank_wdata  = '0;
        o_bank_r_addr = '0;
        o_bank_w_addr = '0;
        if (w_issue) begin
            o_bank_re = w_mask;
        end
        if (w_wr_fire) begin
            o_bank_we    = w_mask;
            o_bank_wdata = i_wr_data;
        end
        for (int i = 0; i < NumBanks; i++) begin
            o_bank_r_addr[i*AddrWidth +: AddrWidth] = w_issue   ? w_addr : '0;
            o_bank_w_addr[i*AddrWidth +: AddrWidth] = w_wr_fire ? w_addr : '0;
        end
    end

    // Zero returned lanes outside the issued mask.
    always_comb begin
        for (int i = 0; i < NumBanks; i++) begin
            w_rdata_masked[i*DataWidth +: DataWidth] =
                i_bank_rdata[i*DataWidth +: DataWidth] & {DataWidth{r_infl_mask[i]}};
        end
    end

    assign o_done = r_done;

    // Command context, beat counter, completion pulse and read-return FIFO.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_vreg      <= '0;
            r_vl        <= '0;
            r_beat      <= '0;
            r_nbeats    <= '0;
            r_done      <= 1'b0;
            r_inflight  <= 1'b0;
            r_infl_mask <= '0;
            r_infl_last <= 1'b0;
            r_fifo_data <= '0;
            r_fifo_mask <= '0;
            r_fifo_last <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_vreg   <= i_cmd_vreg;
                r_vl     <= w_vl_clamped;
                r_nbeats <= w_nbeats_in;
                r_beat   <= '0;
                if (w_vl_clamped == '0) begin
                    r_done <= 1'b1;
                end
            end
            if (w_wr_fire || w_issue) begin
                r_beat <= r_beat + BeatCntW'(1);
            end
            if ((w_wr_fire && w_last_beat) || w_rd_finish) begin
                r_done <= 1'b1;
            end

            r_inflight  <= w_issue;
            r_infl_mask <= w_mask;
            r_infl_last <= w_last_beat;

            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= w_rdata_masked;
                r_fifo_mask[r_wr_ptr] <= r_infl_mask;
                r_fifo_last[r_wr_ptr] <= r_infl_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: doc/vrf_access_seq.md
# vrf_access_seq

Vector register access sequencer: turns whole-register read/write commands (vreg index, vector length) into per-bank request streams for the banked VRF SRAM, and streams read data back out with valid/ready flow control. It sits between the tensor-core issue logic and the VRF. It is the initiator for the SRAM's per-bank re/we/addr/wdata ports and the consumer of its 1-cycle-latency rdata.

## Interface
- NumBanks, 4, banks in the VRF (power of two)
- NumVRs, 32, vector registers
- ElemsPerVR, 32, elements per register (multiple of NumBanks)
- DataWidth, 32, element width
- BeatsPerVR, ElemsPerVR/NumBanks (8), derived
- AddrWidth, $clog2(NumVRs*BeatsPerVR) (8), derived per-bank address width
- VlWidth, $clog2(ElemsPerVR)+1 (6), derived

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write register, 0 = read register
- cmd_vreg  in  $clog2(NumVRs)  target register
- cmd_vl  in  VlWidth  element count, 0..ElemsPerVR (values above ElemsPerVR clamp to ElemsPerVR)
- wr_valid / wr_ready  in / out  1  write-beat handshake
- wr_data  in  NumBanks*DataWidth  one beat; lane i = element b*NumBanks+i
- rd_valid / rd_ready  out / in  1  read-beat handshake
- rd_data  out  NumBanks*DataWidth  read beat; inactive lanes are 0
- rd_mask  out  NumBanks  active lanes of rd_data
- rd_last  out  1  final beat of the command
- done  out  1  one-cycle completion pulse
- bank_re, bank_we  out  NumBanks  per-bank read/write enables to the SRAM
- bank_r_addr, bank_w_addr  out  NumBanks*AddrWidth  per-bank addresses
- bank_wdata  out  NumBanks*DataWidth  per-bank write data
- bank_rdata  in  NumBanks*DataWidth  SRAM read data, valid the cycle after re; 0 for lanes with re low

## Operation
- Mapping: element e of vreg v is stored in bank e%NumBanks at address v*BeatsPerVR + e/NumBanks. Beat b accesses the same address in all banks.
- Beats per command = ceil(vl/NumBanks). Lane mask for beat b: lane i is active iff b*NumBanks+i < vl.
- FSM states: IDLE, WR, RD, RD_DRAIN.
- IDLE: on cmd_valid&&cmd_ready, latch vreg, vl, beat counter=0.
  - vl=0: stay in IDLE; pulse done next cycle; no bank access and no rd beats.
  - Otherwise go to WR (write) or RD (read).
- WR:
  - wr_ready=1.
  - Each wr handshake drives bank_we=lane mask, bank_w_addr=base+b and bank_wdata=wr_data combinationally, then increments b.
  - The handshake on the final beat moves the FSM to IDLE and registers done.
  - Inactive lanes are never written.
- RD: issue a read beat (bank_re=lane mask, bank_r_addr=base+b) when fifo_count - pop + inflight < 2.
  - pop = rd_valid&&rd_ready.
  - inflight = a read was issued last cycle.
  - After the last issue, go to RD_DRAIN.
- Read return: bank_rdata is written into a 2-entry output FIFO, together with the mask and a last flag, the cycle after issue. rd_* present the FIFO head.
- RD_DRAIN: wait for the pop of the rd_last beat. On that edge go to IDLE and register done.
- bank_we is 0 outside WR and bank_re is 0 outside RD. bank_re and bank_we are never both set by this block.
- The FIFO never overflows. There is no stall path into the SRAM.

## Timing
- Reset values: all bank enables 0, addresses and wdata 0, cmd_ready 1 (IDLE), wr_ready 0, rd_valid 0, rd_mask 0, rd_last 0, done 0, FIFO empty, inflight 0.
- cmd accepted at edge 0; first bank access possible in cycle 1.
- Read latency: issue in cycle t, rdata captured at edge end of t+1, rd_valid high in cycle t+2.
- With rd_ready held high, reads issue one beat per cycle; an 8-beat read shows rd_valid in cycles 3..10.
- Write throughput: one beat per cycle while wr_valid is high.
- done is high for exactly one cycle, the cycle after the final write handshake or the final rd pop. cmd_ready is also high in that cycle, so back-to-back commands are allowed.
- Reset mid-command: the FSM, FIFO and counters clear immediately. Enables drop asynchronously and no done is produced.
- rd_ready low: the FIFO fills to 2 and issue stops. Issue resumes within 1 cycle of pops, with no data loss or duplication.

## Test plan
- Write vreg 3, vl=32, lane data = element index -> bank_w_addr 24..31, bank_we=4'hF each beat; then read vreg 3 -> 8 beats with data 0..31, rd_last on beat 8, done once.
- Write then read vreg 31, vl=6 -> 2 beats at addr 248, 249; beat 2 bank_we=4'b0011 and rd_mask=4'b0011 with lanes 2..3 = 0; element 6 is left untouched.
- Read with vl=32 and rd_ready toggling 1,0,0,1 -> FIFO never exceeds 2 entries, data order is preserved, bank_re stops when 2 entries are pending.
- vl=0 read and vl=0 write -> no bank_re/bank_we, no rd_valid, done pulses the cycle after acceptance.
- Assert nrst during beat 4 of a read -> outputs go to reset values; a following full read of the same vreg completes correctly.
- Write with wr_valid gaps (1,0,1,1,0,...) -> bank_we is asserted only on handshake cycles and addresses increment only on handshakes.
